wb_stage: RTL and testbench
===========================

# wb_stage

Write-back end of the five-stage pipeline: consumes the 104-bit MEM/WB packet, selects the write-back value, and commits it into the 32×32 general register file. It also provides:
- the two ID-stage read ports, with same-cycle write-through bypass;
- the write-back forwarding tap used by the EX-stage forwarding unit;
- a committed-write counter and last-write capture for debug.

## Interface
Parameters:
- NREG, 32, number of architectural registers (register 0 is hardwired to zero)
- DW, 32, data width
- CW, 32, commit counter width

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- mem_wb_in  in  104  MEM/WB packet, layout below
- rs_addr  in  5  ID read port A address
- rt_addr  in  5  ID read port B address
- rs_data  out  32  read port A data (combinational)
- rt_data  out  32  read port B data (combinational)
- wb_we  out  1  effective write enable this cycle (combinational)
- wb_rd  out  5  destination register this cycle (combinational)
- wb_data  out  32  selected write-back value this cycle (combinational)
- commit_count  out  CW  number of committed register writes since reset
- last_rd  out  5  destination of the most recent committed write
- last_data  out  32  value of the most recent committed write

## Operation
Packet fields (bit 103 = MSB):
- [103] RegWrite
- [102] MemtoReg
- [101] PctoReg
- [100:69] pc_add (return address)
- [68:37] dm_out
- [36:5] alu_out
- [4:0] rd

Write-back data selection (priority order):
- PctoReg=1 → pc_add
- else MemtoReg=1 → dm_out
- else alu_out
- When PctoReg and MemtoReg are both 1, PctoReg wins.

Write enable:
- wb_we = RegWrite && (rd != 0).
- A write to register 0 is discarded: it is not counted and does not update last_rd/last_data.
- An all-zero packet is a bubble: no write, no count.

Rising edge with wb_we=1:
- reg[rd] ← wb_data
- commit_count += 1, wrapping modulo 2^CW with no saturation
- last_rd ← rd
- last_data ← wb_data

Read ports:
- rs_data = 0 if rs_addr==0.
- Otherwise, if wb_we and rs_addr==wb_rd, rs_data = wb_data (write-through bypass).
- Otherwise, rs_data = reg[rs_addr].
- rt_data follows the identical rule using rt_addr.
- Both ports may bypass in the same cycle.

## Timing
- Reset (asynchronous assert, synchronous release by clock): all registers 0, commit_count 0, last_rd 0, last_data 0.
- With reset low, the combinational outputs still follow mem_wb_in and the addresses, but reads return 0 and no write occurs.
- Reset asserted mid-cycle clears state immediately; a write pending on that cycle is lost.
- Write latency: the value is visible through the bypass in the same cycle, and from the array on every cycle after the edge.
- wb_we, wb_rd and wb_data are purely combinational from mem_wb_in; there is no added latency to the forwarding unit.
- commit_count wrap: at 2^CW−1 plus a commit, the counter reads 0 on the next cycle.
- Back-to-back writes to the same rd: the later write wins; each write is counted.

## Structure
- Package pipe_pkg holds:
  - packet bit-position constants (RW_BIT, M2R_BIT, PC2R_BIT, PC_HI/LO, DM_HI/LO, ALU_HI/LO, RD_HI/LO);
  - MEM_WB_W=104;
  - the wb_sel encoding shared with the controller.
- One sub-module, reg_file: NREG×DW array with async active-low clear, one write port, and two combinational read ports including the zero and bypass logic.
- wb_stage contains the packet decode, the write-back mux, the counter and the last-write capture.

## Test plan
- Reset then read: hold reset low and read rs=5, rt=31 → both 0; commit_count=0.
- ALU write: packet RegWrite=1, MemtoReg=0, PctoReg=0, alu=0x1234_5678, rd=8, with rs_addr=8 in the same cycle → rs_data=0x1234_5678 (bypass). Next cycle, with a bubble packet → still 0x1234_5678; commit_count=1.
- Select priority:
  - MemtoReg=1, dm=0xDEAD_BEEF, rd=3 → reg3=0xDEAD_BEEF.
  - PctoReg=1 and MemtoReg=1, pc_add=0x0000_0040, rd=31 → reg31=0x40.
- Register zero: RegWrite=1, rd=0, alu=0xFFFF_FFFF → wb_we=0; reading rs=0 gives 0; commit_count unchanged; last_rd and last_data unchanged.
- Counter wrap: with CW=4, perform 16 commits → commit_count=0. Perform 17 commits → commit_count=1, and last_data equals the 17th value.
- Reset mid-operation: after writing reg7=0xA5A5_A5A5, pulse reset low between edges → reg7, commit_count, last_rd and last_data are all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MEM/WB packet layout and the write-back select
// encoding used by both the controller and the write-back stage.
package pipe_pkg;

   localparam int unsigned MEM_WB_W = 104;

   localparam int unsigned RW_BIT   = 103;
   localparam int unsigned M2R_BIT  = 102;
   localparam int unsigned PC2R_BIT = 101;
   localparam int unsigned PC_HI    = 100;
   localparam int unsigned PC_LO    = 69;
   localparam int unsigned DM_HI    = 68;
   localparam int unsigned DM_LO    = 37;
   localparam int unsigned ALU_HI   = 36;
   localparam int unsigned ALU_LO   = 5;
   localparam int unsigned RD_HI    = 4;
   localparam int unsigned RD_LO    = 0;

   localparam int unsigned RD_W     = RD_HI - RD_LO + 1;
   localparam int unsigned FIELD_W  = PC_HI - PC_LO + 1;

   typedef enum logic [1:0] {
      WB_SEL_ALU = 2'b00,
      WB_SEL_MEM = 2'b01,
      WB_SEL_PC  = 2'b10
   } wb_sel_e;

   typedef struct packed {
      logic                reg_write;
      logic                mem_to_reg;
      logic                pc_to_reg;
      logic [FIELD_W-1:0]  pc_add;
      logic [FIELD_W-1:0]  dm_out;
      logic [FIELD_W-1:0]  alu_out;
      logic [RD_W-1:0]     rd;
   } mem_wb_t;

   // PctoReg outranks MemtoReg when both are set.
   function automatic wb_sel_e wb_sel_decode(input logic mem_to_reg, input logic pc_to_reg);
      wb_sel_e sel;
      if (pc_to_reg) begin
         sel = WB_SEL_PC;
      end else if (mem_to_reg) begin
         sel = WB_SEL_MEM;
      end else begin
         sel = WB_SEL_ALU;
      end
      return sel;
   endfunction

endpackage

// File: rtl/wb_stage_reg_file.sv
// Architectural register file: one write port, two combinational read ports
// with register-zero and same-cycle write-through handling.
module reg_file
   import pipe_pkg::*;
#(
   parameter int unsigned NREG = 32,
   parameter int unsigned DW   = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            we,
   input  logic [RD_W-1:0] waddr,
   input  logic [DW-1:0]   wdata,
   input  logic [RD_W-1:0] rs_addr,
   input  logic [RD_W-1:0] rt_addr,
   output logic [DW-1:0]   rs_data,
   output logic [DW-1:0]   rt_data
);

   logic [DW-1:0] regs [NREG];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Reads are forced to zero while reset is held, including the bypass path.
   always_comb begin
      rs_data = '0;
      if (reset && (rs_addr != '0)) begin
         if (we && (rs_addr == waddr)) begin
            rs_data = wdata;
         end else begin
            rs_data = regs[rs_addr];
         end
      end
   end

   always_comb begin
      rt_data = '0;
      if (reset && (rt_addr != '0)) begin
         if (we && (rt_addr == waddr)) begin
            rt_data = wdata;
         end else begin
            rt_data = regs[rt_addr];
         end
      end
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: decodes the MEM/WB packet, selects the write-back value,
// commits it to the register file and keeps debug commit tracking.
module wb_stage
   import pipe_pkg::*;
#(
   parameter int unsigned NREG = 32,
   parameter int unsigned DW   = 32,
   parameter int unsigned CW   = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [MEM_WB_W-1:0] mem_wb_in,
   input  logic [RD_W-1:0]     rs_addr,
   input  logic [RD_W-1:0]     rt_addr,
   output logic [DW-1:0]       rs_data,
   output logic [DW-1:0]       rt_data,
   output logic                wb_we,
   output logic [RD_W-1:0]     wb_rd,
   output logic [DW-1:0]       wb_data,
   output logic [CW-1:0]       commit_count,
   output logic [RD_W-1:0]     last_rd,
   output logic [DW-1:0]       last_data
);

   mem_wb_t pkt;
   wb_sel_e wb_sel;

   always_comb begin
      pkt.reg_write  = mem_wb_in[RW_BIT];
      pkt.mem_to_reg = mem_wb_in[M2R_BIT];
      pkt.pc_to_reg  = mem_wb_in[PC2R_BIT];
      pkt.pc_add     = mem_wb_in[PC_HI:PC_LO];
      pkt.dm_out     = mem_wb_in[DM_HI:DM_LO];
      pkt.alu_out    = mem_wb_in[ALU_HI:ALU_LO];
      pkt.rd         = mem_wb_in[RD_HI:RD_LO];
   end

   always_comb begin
      wb_sel = wb_sel_decode(pkt.mem_to_reg, pkt.pc_to_reg);
      unique case (wb_sel)
         WB_SEL_PC:  wb_data = DW'(pkt.pc_add);
         WB_SEL_MEM: wb_data = DW'(pkt.dm_out);
         default:    wb_data = DW'(pkt.alu_out);
      endcase
   end

   assign wb_rd = pkt.rd;
   assign wb_we = pkt.reg_write && (pkt.rd != '0);

   reg_file #(
      .NREG (NREG),
      .DW   (DW)
   ) u_reg_file (
      .clock   (clock),
      .reset   (reset),
      .we      (wb_we),
      .waddr   (wb_rd),
      .wdata   (wb_data),
      .rs_addr (rs_addr),
      .rt_addr (rt_addr),
      .rs_data (rs_data),
      .rt_data (rt_data)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         commit_count <= '0;
         last_rd      <= '0;
         last_data    <= '0;
      end else if (wb_we) begin
         commit_count <= commit_count + CW'(1);
         last_rd      <= wb_rd;
         last_data    <= wb_data;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (counter narrowed to 4 bits so
// the wrap is reachable).
module tb_wb_stage;
   import pipe_pkg::*;

   localparam int unsigned CW = 4;

   logic                clock;
   logic                reset;
   logic [MEM_WB_W-1:0] mem_wb_in;
   logic [4:0]          rs_addr;
   logic [4:0]          rt_addr;
   logic [31:0]         rs_data;
   logic [31:0]         rt_data;
   logic                wb_we;
   logic [4:0]          wb_rd;
   logic [31:0]         wb_data;
   logic [CW-1:0]       commit_count;
   logic [4:0]          last_rd;
   logic [31:0]         last_data;

   int errors = 0;
   int checks = 0;

   wb_stage #(
      .NREG (32),
      .DW   (32),
      .CW   (CW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .mem_wb_in    (mem_wb_in),
      .rs_addr      (rs_addr),
      .rt_addr      (rt_addr),
      .rs_data      (rs_data),
      .rt_data      (rt_data),
      .wb_we        (wb_we),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .commit_count (commit_count),
      .last_rd      (last_rd),
      .last_data    (last_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [MEM_WB_W-1:0] pkt(input logic rw, input logic m2r, input logic pc2r,
                                                input logic [31:0] pc, input logic [31:0] dm,
                                                input logic [31:0] alu, input logic [4:0] rd);
      return {rw, m2r, pc2r, pc, dm, alu, rd};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; checks sample 1 time unit later.
   task automatic step();
      @(negedge clock);
   endtask

   initial begin
      reset     = 1'b0;
      mem_wb_in = '0;
      rs_addr   = 5'd5;
      rt_addr   = 5'd31;
      #12;
      check("rst_rs", rs_data, 32'h0);
      check("rst_rt", rt_data, 32'h0);
      check("rst_cnt", 32'(commit_count), 32'h0);
      check("rst_last_rd", 32'(last_rd), 32'h0);
      check("rst_last_data", last_data, 32'h0);

      // Combinational outputs follow the packet under reset, reads stay 0.
      mem_wb_in = pkt(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0055, 5'd5);
      #1;
      check("rst_wb_we", 32'(wb_we), 32'h1);
      check("rst_wb_data", wb_data, 32'h0000_0055);
      check("rst_bypass_blocked", rs_data, 32'h0);

      step();
      reset     = 1'b1;
      mem_wb_in = '0;
      #1;
      check("rst_no_write", rs_data, 32'h0);
      check("rst_no_count", 32'(commit_count), 32'h0);

      // ALU write with same-cycle bypass
      step();
      mem_wb_in = pkt(1'b1, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h1234_5678, 5'd8);
      rs_addr   = 5'd8;
      rt_addr   = 5'd0;
      #1;
      check("alu_wb_we", 32'(wb_we), 32'h1);
      check("alu_wb_rd", 32'(wb_rd), 32'd8);
      check("alu_wb_data", wb_data, 32'h1234_5678);
      check("alu_bypass_rs", rs_data, 32'h1234_5678);
      check("alu_rt_zero", rt_data, 32'h0);
      check("alu_cnt_before", 32'(commit_count), 32'h0);

      step();
      mem_wb_in = '0;
      #1;
      check("bubble_we", 32'(wb_we), 32'h0);
      check("alu_array_rs", rs_data, 32'h1234_5678);
      check("alu_cnt", 32'(commit_count), 32'd1);
      check("alu_last_rd", 32'(last_rd), 32'd8);
      check("alu_last_data", last_data, 32'h1234_5678);

      // MemtoReg selects dm_out
      step();
      mem_wb_in = pkt(1'b1, 1'b1, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 5'd3);
      #1;
      check("mem_wb_data", wb_data, 32'hDEAD_BEEF);
      step();
      mem_wb_in = '0;
      rs_addr   = 5'd3;
      #1;
      check("mem_reg3", rs_data, 32'hDEAD_BEEF);
      check("mem_cnt", 32'(commit_count), 32'd2);

      // PctoReg outranks MemtoReg
      step();
      mem_wb_in = pkt(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h3333_3333, 32'h4444_4444, 5'd31);
      #1;
      check("pc_wb_data", wb_data, 32'h0000_0040);
      step();
      mem_wb_in = '0;
      rt_addr   = 5'd31;
      #1;
      check("pc_reg31", rt_data, 32'h0000_0040);
      check("pc_reg3_kept", rs_data, 32'hDEAD_BEEF);
      check("pc_cnt", 32'(commit_count), 32'd3);
      check("pc_last_rd", 32'(last_rd), 32'd31);

      // Both ports bypass together; rd=8 overwrite supersedes old value
      step();
      mem_wb_in = pkt(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BAD_CAFE, 5'd8);
      rs_addr   = 5'd8;
      rt_addr   = 5'd8;
      #1;
      check("dual_bypass_rs", rs_data, 32'h0BAD_CAFE);
      check("dual_bypass_rt", rt_data, 32'h0BAD_CAFE);
      step();
      mem_wb_in = '0;
      rt_addr   = 5'd3;
      #1;
      check("overwrite_reg8", rs_data, 32'h0BAD_CAFE);
      check("overwrite_rt_reg3", rt_data, 32'hDEAD_BEEF);
      check("overwrite_cnt", 32'(commit_count), 32'd4);

      // Write to register zero is discarded
      step();
      mem_wb_in = pkt(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd0);
      rs_addr   = 5'd0;
      rt_addr   = 5'd0;
      #1;
      check("r0_wb_we", 32'(wb_we), 32'h0);
      check("r0_wb_data", wb_data, 32'hFFFF_FFFF);
      check("r0_rs", rs_data, 32'h0);
      step();
      mem_wb_in = '0;
      #1;
      check("r0_rs_after", rs_data, 32'h0);
      check("r0_cnt", 32'(commit_count), 32'd4);
      check("r0_last_rd", 32'(last_rd), 32'd8);
      check("r0_last_data", last_data, 32'h0BAD_CAFE);

      // RegWrite=0 with nonzero rd writes nothing
      step();
      mem_wb_in = pkt(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h7777_7777, 5'd9);
      rs_addr   = 5'd9;
      #1;
      check("norw_we", 32'(wb_we), 32'h0);
      check("norw_no_bypass", rs_data, 32'h0);
      step();
      mem_wb_in = '0;
      #1;
      check("norw_reg9", rs_data, 32'h0);
      check("norw_cnt", 32'(commit_count), 32'd4);

      // Asynchronous reset between edges
      mem_wb_in = pkt(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5, 5'd7);
      step();
      mem_wb_in = '0;
      rs_addr   = 5'd7;
      #1;
      check("r7_written", rs_data, 32'hA5A5_A5A5);
      check("r7_cnt", 32'(commit_count), 32'd5);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_r7", rs_data, 32'h0);
      check("async_rst_cnt", 32'(commit_count), 32'h0);
      check("async_rst_last_rd", 32'(last_rd), 32'h0);
      check("async_rst_last_data", last_data, 32'h0);
      mem_wb_in = pkt(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1357_9BDF, 5'd10);
      rs_addr   = 5'd10;
      step();
      reset     = 1'b1;
      mem_wb_in = '0;
      #1;
      check("rst_pending_lost", rs_data, 32'h0);
      check("rst_pending_cnt", 32'(commit_count), 32'h0);

      // 16 back-to-back commits to rd=20 wrap the 4-bit counter to 0
      rs_addr = 5'd20;
      for (int i = 0; i < 16; i++) begin
         step();
         mem_wb_in = pkt(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0100 + 32'(i), 5'd20);
      end
      step();
      mem_wb_in = '0;
      #1;
      check("wrap16_cnt", 32'(commit_count), 32'h0);
      check("b2b_last_wins", rs_data, 32'h0000_010F);
      check("wrap16_last_data", last_data, 32'h0000_010F);

      step();
      mem_wb_in = pkt(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1000_0017, 5'd21);
      step();
      mem_wb_in = '0;
      rt_addr   = 5'd21;
      #1;
      check("wrap17_cnt", 32'(commit_count), 32'd1);
      check("wrap17_last_data", last_data, 32'h1000_0017);
      check("wrap17_last_rd", 32'(last_rd), 32'd21);
      check("wrap17_reg21", rt_data, 32'h1000_0017);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
